// File: rtl/uart_rx_frame_parser_pkg.sv
// rtl/uart_rx_frame_parser_pkg.sv - shared state encoding, SOF default and buffer address helper
package uart_rx_frame_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// rtl/uart_rx_frame_parser_if.sv - receiver input, payload stream and status pulses of the frame parser
interface uart_rx_frame_parser_if;
  logic [7:0] i_RxByte;
  logic       i_RxDone;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       i_Ready;
  logic       o_Last;
  logic       o_FrameOk;
  logic       o_FrameErr;
  logic       o_Overrun;

  modport slave (
    input  i_RxByte, i_RxDone, i_Ready,
    output o_Data, o_Valid, o_Last, o_FrameOk, o_FrameErr, o_Overrun
  );

  modport master (
    output i_RxByte, i_RxDone, i_Ready,
    input  o_Data, o_Valid, o_Last, o_FrameOk, o_FrameErr, o_Overrun
  );
endinterface

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload store: synchronous write, combinational read
module uart_frame_buf
  import uart_rx_frame_parser_pkg::*;
#(
  parameter int MAX_LEN = 16,
  localparam int AW = addr_width(MAX_LEN)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - SOF/LEN/payload/CHK frame parser with buffered payload replay
// Optional inter-byte gap timeout is built when RX_TIMEOUT_EN is defined.
module uart_rx_frame_parser
  import uart_rx_frame_parser_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
  parameter int MAX_LEN = 16
`ifdef RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
  input logic             i_SysClock,
  input logic             i_ResetN,
  uart_rx_frame_parser_if.slave bus
);

  localparam int AW = addr_width(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state;
  logic       done_q;
  logic [7:0] len, idx, rd, chk;
  logic       valid, last, frame_ok, frame_err, overrun;
  logic       rx_stb, wr_en, accept;
  logic [7:0] rx_byte, buf_data;

  assign rx_byte = bus.i_RxByte;
  assign rx_stb  = bus.i_RxDone & ~done_q;
  assign wr_en   = rx_stb && (state == ST_PAYLOAD);
  assign accept  = valid && bus.i_Ready;

  uart_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk     (i_SysClock),
    .wr_en   (wr_en),
    .wr_addr (idx[AW-1:0]),
    .wr_data (rx_byte),
    .rd_addr (rd[AW-1:0]),
    .rd_data (buf_data)
  );

`ifdef RX_TIMEOUT_EN
  logic [31:0] gap;
`endif

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state     <= ST_IDLE;
      done_q    <= 1'b1;
      len       <= 8'd0;
      idx       <= 8'd0;
      rd        <= 8'd0;
      chk       <= 8'd0;
      valid     <= 1'b0;
      last      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef RX_TIMEOUT_EN
      gap       <= 32'd0;
`endif
    end else begin
      done_q    <= bus.i_RxDone;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_stb && rx_byte == SOF_BYTE) state <= ST_LEN;
        end
        ST_LEN: begin
          if (rx_stb) begin
            len <= rx_byte;
            chk <= rx_byte;
            idx <= 8'd0;
            if (rx_byte == 8'd0) begin
              state <= ST_CHK;
            end else if (rx_byte > MAX_LEN_B) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_stb) begin
            chk <= chk ^ rx_byte;
            idx <= idx + 8'd1;
            if (idx == len - 8'd1) state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (rx_stb) begin
            if (rx_byte == chk) begin
              frame_ok <= 1'b1;
              if (len != 8'd0) begin
                valid <= 1'b1;
                rd    <= 8'd0;
                last  <= (len == 8'd1);
                state <= ST_DRAIN;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          // Receiver bytes cannot be parsed while replaying; flag and drop them.
          if (rx_stb) overrun <= 1'b1;
          if (accept) begin
            if (last) begin
              valid <= 1'b0;
              last  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              rd   <= rd + 8'd1;
              last <= (rd + 8'd2 == len);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef RX_TIMEOUT_EN
      if ((state inside {ST_LEN, ST_PAYLOAD, ST_CHK}) && !rx_stb) begin
        if (gap == 32'(TIMEOUT_CYCLES - 1)) begin
          gap       <= 32'd0;
          frame_err <= 1'b1;
          state     <= ST_IDLE;
        end else begin
          gap <= gap + 32'd1;
        end
      end else begin
        gap <= 32'd0;
      end
`endif
    end
  end

  // Gating with valid keeps o_Data at 0 outside replay, including after reset.
  assign bus.o_Data     = valid ? buf_data : 8'd0;
  assign bus.o_Valid    = valid;
  assign bus.o_Last     = last;
  assign bus.o_FrameOk  = frame_ok;
  assign bus.o_FrameErr = frame_err;
  assign bus.o_Overrun  = overrun;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb/tb_uart_rx_frame_parser.sv - directed frames with hand-computed checksums and expected stream
module tb_uart_rx_frame_parser;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_parser_if bus();

`ifdef RX_TIMEOUT_EN
  uart_rx_frame_parser #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(100)) dut (
    .i_SysClock (clk),
    .i_ResetN   (rst_n),
    .bus        (bus)
  );
`else
  uart_rx_frame_parser #(.SOF_BYTE(8'hA5), .MAX_LEN(16)) dut (
    .i_SysClock (clk),
    .i_ResetN   (rst_n),
    .bus        (bus)
  );
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Cumulative monitor counts; tests work on deltas from a snapshot.
  int n_ok = 0, n_err = 0, n_ovr = 0, n_valid = 0;
  logic [8:0] got[$];
  int b_ok, b_err, b_ovr, b_valid, b_got;
  byte_q_t frame;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_FrameOk)  n_ok++;
      if (bus.o_FrameErr) n_err++;
      if (bus.o_Overrun)  n_ovr++;
      if (bus.o_Valid)    n_valid++;
      if (bus.o_Valid && bus.i_Ready) got.push_back({bus.o_Last, bus.o_Data});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_ok = n_ok; b_err = n_err; b_ovr = n_ovr; b_valid = n_valid; b_got = got.size();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_RxByte = b;
    bus.i_RxDone = 1'b0;
    @(posedge clk); #1;
    bus.i_RxDone = 1'b1;
  endtask

  task automatic send_bytes(input byte_q_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] got_at(input int i);
    return (b_got + i < got.size()) ? got[b_got + i] : 9'h1FF;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fire;
    bus.i_RxByte = 8'h00;
    bus.i_RxDone = 1'b1;
    bus.i_Ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.o_Valid, bus.o_Last, bus.o_FrameOk, bus.o_FrameErr, bus.o_Overrun, bus.o_Data}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Good 3-byte frame: CHK = 03^11^22^33 = 03
    snap();
    frame = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_bytes(frame);
    send_byte(8'h03);
    @(negedge clk); check("t1_no_valid_in_stb_cycle", bus.o_Valid, 1'b0);
    @(negedge clk); check("t1_beat0", {bus.o_Valid, bus.o_FrameOk, bus.o_Last, bus.o_Data}, {3'b110, 8'h11});
    @(negedge clk); check("t1_beat1", {bus.o_Valid, bus.o_FrameOk, bus.o_Last, bus.o_Data}, {3'b100, 8'h22});
    @(negedge clk); check("t1_beat2", {bus.o_Valid, bus.o_FrameOk, bus.o_Last, bus.o_Data}, {3'b101, 8'h33});
    @(negedge clk); check("t1_valid_drop", bus.o_Valid, 1'b0);
    check("t1_ok_count", n_ok - b_ok, 1);
    check("t1_err_count", n_err - b_err, 0);

    // Checksum without LEN folded in must be rejected
    snap();
    frame = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    send_bytes(frame);
    idle(4);
    check("t1b_err_count", n_err - b_err, 1);
    check("t1b_no_valid", n_valid - b_valid, 0);

    // Bad checksum: 02^10^20 = 32, sent 31
    snap();
    frame = '{8'hA5, 8'h02, 8'h10, 8'h20};
    send_bytes(frame);
    send_byte(8'h31);
    @(negedge clk); check("t2_err_early", bus.o_FrameErr, 1'b0);
    @(negedge clk); check("t2_err_pulse", bus.o_FrameErr, 1'b1);
    @(negedge clk); check("t2_err_one_cycle", bus.o_FrameErr, 1'b0);
    idle(4);
    check("t2_no_valid", n_valid - b_valid, 0);
    check("t2_no_ok", n_ok - b_ok, 0);
    snap();
    frame = '{8'hA5, 8'h01, 8'h44, 8'h45};
    send_bytes(frame);
    idle(4);
    check("t2_next_frame_ok", n_ok - b_ok, 1);
    check("t2_next_frame_data", got_at(0), {1'b1, 8'h44});

    // Length limits: 17 rejected at LEN, 0 accepted without data, 16 accepted
    snap();
    frame = '{8'hA5, 8'h11};
    send_bytes(frame);
    @(negedge clk);
    @(negedge clk); check("t3_len17_err", bus.o_FrameErr, 1'b1);
    frame = '{8'hA5, 8'h00, 8'h00};
    send_bytes(frame);
    idle(4);
    check("t3_len0_ok", n_ok - b_ok, 1);
    check("t3_len0_no_valid", n_valid - b_valid, 0);
    check("t3_err_total", n_err - b_err, 1);
    snap();
    frame = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) frame.push_back(8'(i));
    frame.push_back(8'h10);
    send_bytes(frame);
    idle(20);
    check("t3_len16_count", got.size() - b_got, 16);
    check("t3_len16_first", got_at(0), {1'b0, 8'h00});
    check("t3_len16_last", got_at(15), {1'b1, 8'h0F});

    // Backpressure + overrun: CHK = 02^5A^C3 = 9B
    snap();
    bus.i_Ready = 1'b0;
    frame = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B};
    send_bytes(frame);
    idle(2);
    @(negedge clk); check("t4_hold_first", {bus.o_Valid, bus.o_Last, bus.o_Data}, {2'b10, 8'h5A});
    send_byte(8'hA5);
    idle(5);
    @(negedge clk); check("t4_hold_after_overrun", {bus.o_Valid, bus.o_Last, bus.o_Data}, {2'b10, 8'h5A});
    check("t4_overrun_once", n_ovr - b_ovr, 1);
    @(posedge clk); #1 bus.i_Ready = 1'b1;
    idle(4);
    check("t4_drain_count", got.size() - b_got, 2);
    check("t4_drain_b0", got_at(0), {1'b0, 8'h5A});
    check("t4_drain_b1", got_at(1), {1'b1, 8'hC3});
    // If the dropped A5 had been taken as SOF, 01,66,67 would complete a good frame
    frame = '{8'h01, 8'h66, 8'h67};
    send_bytes(frame);
    idle(4);
    check("t4_a5_not_sof", n_ok - b_ok, 1);
    check("t4_no_err", n_err - b_err, 0);

    // Reset mid-payload, then noise and a 1-byte frame: CHK = 01^7E = 7F
    frame = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_bytes(frame);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("t5_reset_outputs", {bus.o_Valid, bus.o_Last, bus.o_FrameOk, bus.o_FrameErr, bus.o_Overrun, bus.o_Data}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    snap();
    frame = '{8'h55, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_bytes(frame);
    idle(4);
    check("t5_count", got.size() - b_got, 1);
    check("t5_byte", got_at(0), {1'b1, 8'h7E});
    check("t5_ok_no_err", {n_ok - b_ok, n_err - b_err}, {32'd1, 32'd0});

`ifdef RX_TIMEOUT_EN
    snap();
    fire = 0;
    frame = '{8'hA5, 8'h02, 8'h01};
    send_bytes(frame);
    @(posedge clk);
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.o_FrameErr && fire == 0) fire = k;
    end
    #1;
    check("t6_timeout_cycle", fire, 100);
    check("t6_err_count", n_err - b_err, 1);
    snap();
    frame = '{8'hA5, 8'h01, 8'h44, 8'h45};
    send_bytes(frame);
    idle(4);
    check("t6_next_frame", got_at(0), {1'b1, 8'h44});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
